// File: rtl/core_pkg.sv
// Shared core constants and helpers, including the ASCII helpers used by the PC trace port.
package core_pkg;

   localparam int unsigned INST_MEM_ADDR_WIDTH = 12;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   function automatic logic [7:0] hex_to_ascii(logic [3:0] nib);
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end
      return 8'h37 + {4'h0, nib};
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, d0..d7 LSB first, stop bit, each CLKS_PER_BIT cycles long.
module uart_tx_byte #(
   parameter int unsigned CLKS_PER_BIT = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       done_o,
   output logic       tx_o
);
   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_byte: CLKS_PER_BIT must be at least 2");
   end

   logic          r_busy;
   logic [CW-1:0] r_clk_cnt;
   logic [3:0]    r_bit_cnt;
   logic [8:0]    r_shift;
   logic          r_tx;
   logic          r_done;
   logic          w_bit_end;

   assign w_bit_end = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
   assign ready_o   = !r_busy;
   assign done_o    = r_done;
   assign tx_o      = r_tx;

   // r_bit_cnt: 0 = start, 1..8 = data, 9 = stop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy    <= 1'b0;
         r_clk_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '1;
         r_tx      <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (!r_busy) begin
            if (valid_i) begin
               r_busy    <= 1'b1;
               r_tx      <= 1'b0;
               r_shift   <= {1'b1, data_i};
               r_clk_cnt <= '0;
               r_bit_cnt <= '0;
            end
         end else if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == 4'd9) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end else begin
               r_bit_cnt <= r_bit_cnt + 4'd1;
               r_tx      <= r_shift[0];
               r_shift   <= {1'b1, r_shift[8:1]};
            end
         end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/pc_trace_uart.sv
// Streams every new PC value out of a UART pin as uppercase hex plus CR LF, one line per value.
module pc_trace_uart
   import core_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = INST_MEM_ADDR_WIDTH,
   parameter int unsigned CLK_FREQ_HZ = 125_000_000,
   parameter int unsigned BAUD_RATE   = 115_200,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_i,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  overflow_o
);
   localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int unsigned NDIG         = (ADDR_WIDTH + 3) / 4;
   localparam int unsigned NCHAR        = NDIG + 2;
   localparam int unsigned PW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNTW         = PW + 1;
   localparam int unsigned IW           = $clog2(NCHAR);
   localparam logic [IW-1:0]   LAST_IDX = IW'(NCHAR - 1);
   localparam logic [IW-1:0]   CR_IDX   = IW'(NDIG);
   localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
      $error("pc_trace_uart: FIFO_DEPTH must be a power of two and at least 2");
   end

   typedef enum logic [1:0] {IDLE, SEND, WAIT} trace_state_e;

   logic [ADDR_WIDTH-1:0] r_fifo [FIFO_DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CNTW-1:0]       r_count;
   logic [ADDR_WIDTH-1:0] r_last_pc;
   logic                  r_overflow;
   logic                  r_busy;
   trace_state_e          r_state;
   logic [ADDR_WIDTH-1:0] r_line_pc;
   logic [IW-1:0]         r_idx;
   logic                  r_valid;

   logic                  w_push_try;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_ready;
   logic                  w_done;
   logic [CNTW-1:0]       w_count_nxt;
   logic [NDIG*4-1:0]     w_pc_pad;
   logic [3:0]            w_nibble;
   logic [7:0]            w_char;

   assign w_push_try = en_i && (pc_i != r_last_pc);
   assign w_full     = (r_count == FULL_CNT);
   assign w_empty    = (r_count == '0);
   // Popping straight out of WAIT on the last char keeps the inter-line gap at two cycles.
   assign w_pop      = !w_empty && ((r_state == IDLE) ||
                                    ((r_state == WAIT) && w_done && (r_idx == LAST_IDX)));
   assign w_push     = w_push_try && (!w_full || w_pop);

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + CNTW'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - CNTW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_last_pc  <= '1;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_try) r_last_pc <= pc_i;
         if (w_push)     r_wr_ptr  <= r_wr_ptr + PW'(1);
         if (w_pop)      r_rd_ptr  <= r_rd_ptr + PW'(1);
         r_count <= w_count_nxt;
         if (w_push_try && !w_push) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wr_ptr] <= pc_i;
   end

   always_comb begin
      w_pc_pad = '0;
      w_pc_pad[ADDR_WIDTH-1:0] = r_line_pc;
      w_nibble = '0;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (r_idx == IW'(i)) w_nibble = w_pc_pad[(NDIG-1-i)*4 +: 4];
      end
      if (r_idx == CR_IDX) begin
         w_char = ASCII_CR;
      end else if (r_idx == LAST_IDX) begin
         w_char = ASCII_LF;
      end else begin
         w_char = hex_to_ascii(w_nibble);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_line_pc <= '0;
         r_idx     <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_busy <= (w_count_nxt != '0) || (r_state != IDLE);
         unique case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_line_pc <= r_fifo[r_rd_ptr];
                  r_idx     <= '0;
                  r_valid   <= 1'b1;
                  r_state   <= SEND;
                  r_busy    <= 1'b1;
               end
            end
            SEND: begin
               if (w_ready) begin
                  r_valid <= 1'b0;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (w_done) begin
                  if (r_idx != LAST_IDX) begin
                     r_idx   <= r_idx + IW'(1);
                     r_valid <= 1'b1;
                     r_state <= SEND;
                  end else if (w_pop) begin
                     r_line_pc <= r_fifo[r_rd_ptr];
                     r_idx     <= '0;
                     r_valid   <= 1'b1;
                     r_state   <= SEND;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= (w_count_nxt != '0);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk    (clk),
      .rst_n  (rst_n),
      .data_i (w_char),
      .valid_i(r_valid),
      .ready_o(w_ready),
      .done_o (w_done),
      .tx_o   (tx_o)
   );

   assign busy_o     = r_busy;
   assign overflow_o = r_overflow;

endmodule

// File: tb/tb_pc_trace_uart.sv
// Randomized self-checking bench: UART monitor decodes tx_o, a line-level model predicts output.
module tb_pc_trace_uart;
   localparam int unsigned AW    = 12;
   localparam int unsigned CPB   = 10;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned NCH   = 5;
   localparam int unsigned LW    = 8 * NCH;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en_i;
   logic [AW-1:0] pc_i;
   logic          tx_o;
   logic          busy_o;
   logic          overflow_o;

   always #5 clk = ~clk;

   pc_trace_uart #(
      .ADDR_WIDTH (AW),
      .CLK_FREQ_HZ(1_000_000),
      .BAUD_RATE  (100_000),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en_i),
      .pc_i      (pc_i),
      .tx_o      (tx_o),
      .busy_o    (busy_o),
      .overflow_o(overflow_o)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] rx_q[$];
   int         rst_cnt = 0;

   always @(negedge rst_n) rst_cnt++;

   // Frames cut by a reset are discarded
   always begin : uart_monitor
      int         start_rst;
      logic [7:0] b;
      logic       ok;
      @(negedge clk);
      if (rst_n === 1'b1 && tx_o === 1'b0) begin
         start_rst = rst_cnt;
         repeat (CPB / 2) @(negedge clk);
         ok = (tx_o === 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = tx_o;
         end
         repeat (CPB) @(negedge clk);
         ok = ok && (tx_o === 1'b1) && (rst_cnt == start_rst) && (rst_n === 1'b1);
         if (ok) rx_q.push_back(b);
      end
   end

   // Line-level model: a burst started from idle can absorb DEPTH+1 samples
   logic [AW-1:0] m_last;
   int            m_room;
   logic          m_ovf;
   logic [LW-1:0] exp_q[$];

   function automatic logic [7:0] ascii_hex(input logic [3:0] n);
      string digits;
      digits = "0123456789ABCDEF";
      return digits[int'(n)];
   endfunction

   function automatic logic [LW-1:0] line_of(input logic [AW-1:0] pc);
      return {ascii_hex(pc[11:8]), ascii_hex(pc[7:4]), ascii_hex(pc[3:0]), 8'h0D, 8'h0A};
   endfunction

   task automatic model_reset();
      m_last = '1;
      m_ovf  = 1'b0;
      m_room = DEPTH + 1;
      exp_q.delete();
   endtask

   task automatic model_step(input logic en, input logic [AW-1:0] pc);
      if (en && pc != m_last) begin
         m_last = pc;
         if (m_room > 0) begin
            exp_q.push_back(line_of(pc));
            m_room--;
         end else begin
            m_ovf = 1'b1;
         end
      end
   endtask

   task automatic drive_cycle(input logic en, input logic [AW-1:0] pc);
      @(negedge clk);
      en_i = en;
      pc_i = pc;
      model_step(en, pc);
   endtask

   task automatic collect_line(output logic [LW-1:0] line, output bit ok);
      int t;
      ok   = 1'b1;
      line = '0;
      for (int c = 0; c < NCH; c++) begin
         t = 0;
         while (rx_q.size() == 0 && t < 3000) begin
            @(negedge clk);
            t++;
         end
         if (rx_q.size() == 0) begin
            ok = 1'b0;
            return;
         end
         line = {line[LW-9:0], rx_q.pop_front()};
      end
   endtask

   task automatic wait_idle(output bit ok);
      int t;
      t = 0;
      while (busy_o !== 1'b0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      ok = (busy_o === 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en_i  = 1'b0;
      pc_i  = '0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (tx_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx: got %b expected 1", tx_o);
      end
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b expected 0", busy_o);
      end
      checks++;
      if (overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_overflow: got %b expected 0", overflow_o);
      end
   endtask

   task automatic test_first_line();
      logic [9:0]    fr;
      int            bad;
      int            first_bad;
      logic [LW-1:0] line;
      logic [LW-1:0] exp;
      bit            ok;
      en_i = 1'b1;
      pc_i = 12'h004;
      @(negedge clk);
      rst_n = 1'b1;
      model_step(1'b1, 12'h004);
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b1) begin
         errors++;
         $display("FAIL busy_rise: got %b expected 1", busy_o);
      end
      @(negedge clk);
      checks++;
      if (tx_o !== 1'b1) begin
         errors++;
         $display("FAIL tx_before_start: got %b expected 1", tx_o);
      end
      @(negedge clk);
      checks++;
      if (tx_o !== 1'b0) begin
         errors++;
         $display("FAIL start_latency: got %b expected 0", tx_o);
      end
      fr        = {1'b1, ascii_hex(4'h0), 1'b0};
      bad       = 0;
      first_bad = -1;
      for (int j = 0; j < int'(10 * CPB); j++) begin
         if (j > 0) @(negedge clk);
         if (tx_o !== fr[j / int'(CPB)]) begin
            if (first_bad < 0) first_bad = j;
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL frame_timing: got %0d wrong cycles (first at %0d) expected 0", bad,
                  first_bad);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (tx_o !== 1'b0) begin
         errors++;
         $display("FAIL char_gap: got tx %b two idle cycles after stop, expected 0", tx_o);
      end
      collect_line(line, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || line !== exp) begin
         errors++;
         $display("FAIL first_line: got %h (complete=%0d) expected %h", line, ok, exp);
      end
      wait_idle(ok);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL busy_end: got %b expected 0", busy_o);
      end
      checks++;
      if (rx_q.size() != 0) begin
         errors++;
         $display("FAIL first_extra: got %0d extra bytes expected 0", rx_q.size());
      end
   endtask

   task automatic test_pc_steps();
      logic [AW-1:0] steps[4];
      logic [LW-1:0] line;
      logic [LW-1:0] exp;
      bit            ok;
      int            n;
      steps  = '{12'h000, 12'h004, 12'h008, 12'hABC};
      m_room = DEPTH + 1;
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, steps[i]);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         collect_line(line, ok);
         exp = exp_q.pop_front();
         checks++;
         if (!ok || line !== exp) begin
            errors++;
            $display("FAIL steps_line%0d: got %h (complete=%0d) expected %h", i, line, ok, exp);
         end
      end
      checks++;
      if (overflow_o !== m_ovf) begin
         errors++;
         $display("FAIL steps_overflow: got %b expected %b", overflow_o, m_ovf);
      end
      wait_idle(ok);
      checks++;
      if (!ok || rx_q.size() != 0) begin
         errors++;
         $display("FAIL steps_extra: got %0d extra bytes (idle=%0d) expected 0", rx_q.size(), ok);
      end
   endtask

   task automatic test_enable_gate();
      logic [LW-1:0] line;
      logic [LW-1:0] exp;
      bit            ok;
      m_room = DEPTH + 1;
      repeat (3) drive_cycle(1'b0, 12'h010);
      repeat (3) drive_cycle(1'b0, 12'h020);
      repeat (4) drive_cycle(1'b1, 12'h020);
      collect_line(line, ok);
      exp = line_of(12'h020);
      checks++;
      if (!ok || line !== exp) begin
         errors++;
         $display("FAIL enable_line: got %h (complete=%0d) expected %h", line, ok, exp);
      end
      exp_q.delete();
      wait_idle(ok);
      repeat (2 * CPB) @(negedge clk);
      checks++;
      if (!ok || rx_q.size() != 0) begin
         errors++;
         $display("FAIL enable_extra: got %0d extra bytes (idle=%0d) expected 0", rx_q.size(), ok);
      end
   endtask

   task automatic test_overflow();
      logic [LW-1:0] line;
      logic [LW-1:0] exp;
      bit            ok;
      int            n;
      m_room = DEPTH + 1;
      for (int i = 0; i < 6; i++) drive_cycle(1'b1, 12'h100 + 12'(i));
      checks++;
      if (overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL ovf_before_drop: got %b expected 0", overflow_o);
      end
      @(negedge clk);
      checks++;
      if (overflow_o !== m_ovf) begin
         errors++;
         $display("FAIL ovf_rise: got %b expected %b", overflow_o, m_ovf);
      end
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         collect_line(line, ok);
         exp = exp_q.pop_front();
         checks++;
         if (!ok || line !== exp) begin
            errors++;
            $display("FAIL ovf_line%0d: got %h (complete=%0d) expected %h", i, line, ok, exp);
         end
      end
      wait_idle(ok);
      checks++;
      if (!ok || rx_q.size() != 0) begin
         errors++;
         $display("FAIL ovf_extra: got %0d extra bytes (idle=%0d) expected 0", rx_q.size(), ok);
      end
      checks++;
      if (overflow_o !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: got %b expected 1", overflow_o);
      end
   endtask

   task automatic test_reset_midframe();
      logic [LW-1:0] line;
      logic [LW-1:0] exp;
      bit            ok;
      bit            seen;
      rx_q.delete();
      m_room = DEPTH + 1;
      drive_cycle(1'b1, 12'h055);
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         seen = (tx_o === 1'b0);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL mid_start: got no start bit expected one within 20 cycles");
      end
      repeat (4 * CPB + CPB / 2) @(negedge clk);
      #1;
      rst_n = 1'b0;
      en_i  = 1'b0;
      model_reset();
      #1;
      checks++;
      if (tx_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_tx: got %b expected 1", tx_o);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (overflow_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_flags: got ovf=%b busy=%b expected 0 0", overflow_o, busy_o);
      end
      rst_n = 1'b1;
      repeat (30 * CPB) @(negedge clk);
      checks++;
      if (rx_q.size() != 0 || tx_o !== 1'b1) begin
         errors++;
         $display("FAIL mid_quiet: got %0d bytes tx=%b expected 0 bytes tx=1", rx_q.size(), tx_o);
      end
      drive_cycle(1'b1, 12'h0FF);
      collect_line(line, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || line !== exp) begin
         errors++;
         $display("FAIL mid_recover_line: got %h (complete=%0d) expected %h", line, ok, exp);
      end
      wait_idle(ok);
   endtask

   task automatic test_random();
      logic [AW-1:0] pool[3];
      logic [LW-1:0] line;
      logic [LW-1:0] exp;
      bit            ok;
      int            cyc;
      int            n;
      for (int r = 0; r < 12; r++) begin
         wait_idle(ok);
         repeat (2) @(negedge clk);
         m_room = DEPTH + 1;
         for (int k = 0; k < 3; k++) pool[k] = AW'($urandom);
         cyc = $urandom_range(1, 8);
         for (int c = 0; c < cyc; c++) begin
            drive_cycle(($urandom_range(0, 3) != 0), pool[$urandom_range(0, 2)]);
         end
         n = exp_q.size();
         for (int i = 0; i < n; i++) begin
            collect_line(line, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || line !== exp) begin
               errors++;
               $display("FAIL rand%0d_line%0d: got %h (complete=%0d) expected %h", r, i, line,
                        ok, exp);
            end
         end
         wait_idle(ok);
         checks++;
         if (!ok || rx_q.size() != 0) begin
            errors++;
            $display("FAIL rand%0d_extra: got %0d extra bytes (idle=%0d) expected 0", r,
                     rx_q.size(), ok);
         end
         checks++;
         if (overflow_o !== m_ovf) begin
            errors++;
            $display("FAIL rand%0d_overflow: got %b expected %b", r, overflow_o, m_ovf);
         end
      end
   endtask

   initial begin
      test_reset();
      test_first_line();
      test_pc_steps();
      test_enable_gate();
      test_overflow();
      test_reset_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
